timed_counter: RTL and testbench
================================

TIMED_COUNTER -- requirements
Module: timed_counter

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 The block SHALL have parameter TICK_HZ, default 1, count-step rate in Hz, with DIV = CLK_HZ/TICK_HZ and DIV >= 2.
REQ-003 The block SHALL have parameter WIDTH, default 32, the counter width in bits.
REQ-004 The block SHALL have parameter MAX_VAL, default 255, the inclusive top of the count range, with MAX_VAL < 2^WIDTH.
REQ-005 The block SHALL have parameter DIGITS, default 10, the BCD digit count, with 10^DIGITS > MAX_VAL.
REQ-006 clk  input  1  system clock.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 en  input  1  run enable; when low, prescaler and count pause.
REQ-009 dir  input  1  count direction: 0 = up, 1 = down.
REQ-010 clear  input  1  synchronous clear.
REQ-011 load  input  1  synchronous load strobe.
REQ-012 load_val  input  WIDTH  value taken on load.
REQ-013 count  output  WIDTH  registered count value.
REQ-014 tick  output  1  one-cycle pulse, asserted on each count step.
REQ-015 wrap  output  1  one-cycle pulse, asserted on each wrap-around step.
REQ-016 bcd_data  output  4*DIGITS  BCD image of count (TIMED_COUNTER_BCD_EN only).
REQ-017 bcd_valid  output  1  bcd_data matches count (TIMED_COUNTER_BCD_EN only).

Function
REQ-018 The prescaler SHALL count 0..DIV-1 while en=1, SHALL hold while en=0, and SHALL return to 0 after DIV-1.
REQ-019 A step SHALL occur on the clock edge where the prescaler equals DIV-1 and en=1; count, tick and wrap SHALL all update on that edge.
REQ-020 Up step: count=MAX_VAL SHALL give count<=0 with wrap=1; otherwise count<=count+1 with wrap=0.
REQ-021 Down step: count=0 SHALL give count<=MAX_VAL with wrap=1; otherwise count<=count-1 with wrap=0.
REQ-022 tick and wrap SHALL be 0 on every cycle without a step.
REQ-023 Priority SHALL be clear > load > step, with en ignored for clear and load.
REQ-024 clear SHALL set count and the prescaler to 0, and SHALL suppress tick and wrap that cycle.
REQ-025 load SHALL set count to min(load_val, MAX_VAL) and the prescaler to 0, and SHALL suppress tick and wrap.
REQ-026 A change of dir SHALL take effect on the next step, and the prescaler SHALL NOT be disturbed.
REQ-027 count SHALL never exceed MAX_VAL.

Reset
REQ-028 When rst_n=0, the block SHALL asynchronously set count=0, prescaler=0, tick=0 and wrap=0.
REQ-029 When rst_n=0, the block SHALL also set bcd_data=0 and bcd_valid=1, since 0 is a consistent BCD image.
REQ-030 Reset asserted mid-conversion or mid-period SHALL abandon all in-flight state.
REQ-031 After rst_n deasserts, the first step SHALL occur DIV enabled cycles later.

Configuration
REQ-032 With macro TIMED_COUNTER_BCD_EN defined, the block SHALL include an iterative shift-add-3 binary-to-BCD converter that uses one cycle per bit, WIDTH cycles per conversion.
REQ-033 A conversion SHALL start on the cycle after any count change, and bcd_valid SHALL drop to 0 on that cycle.
REQ-034 On completion, bcd_data SHALL update and bcd_valid SHALL return to 1.
REQ-035 A count change during a conversion SHALL restart the conversion with the new value; a stale result SHALL never be flagged valid.
REQ-036 With TIMED_COUNTER_BCD_EN undefined, ports bcd_data and bcd_valid and all converter logic SHALL be absent, and the remaining behaviour SHALL be unchanged.

Verification
All scenarios use CLK_HZ=10, TICK_HZ=1 (DIV=10), WIDTH=8, MAX_VAL=5, DIGITS=2.
REQ-037 Scenario: reset release, en=1, dir=0 -> tick every 10 cycles; count 0,1,2,3,4,5,0; wrap=1 only on the 5->0 step.
REQ-038 Scenario: dir=1 from count=0 -> first step gives count=5 with wrap=1, then 4,3, with wrap=0.
REQ-039 Scenario: en=0 for 7 cycles with prescaler at 4 -> no tick; after en=1 returns, next tick comes 6 enabled cycles later.
REQ-040 Scenario: load=1, load_val=200, on the same cycle as a step -> count=5, tick=0, next tick 10 cycles later.
REQ-041 Scenario: clear and load together at count=3 -> count=0 with no tick.
REQ-042 Scenario (BCD_EN): load_val=4, then load_val=2 three cycles later -> bcd_valid stays 0 until 8 cycles after the second load, then bcd_data=8'h02.

Source files
------------

// File: rtl/timed_counter.sv
// timed_counter: prescaled up/down counter over 0..MAX_VAL with tick/wrap
// pulses, synchronous clear/load and asynchronous active-low reset.
// Optional feature macro: TIMED_COUNTER_BCD_EN adds an iterative
// shift-add-3 binary-to-BCD converter (bcd_data / bcd_valid ports).
module timed_counter #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1,
    parameter int WIDTH   = 32,
    parameter int MAX_VAL = 255,
    parameter int DIGITS  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  clear,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    output logic [WIDTH-1:0]      count,
    output logic                  tick,
    output logic                  wrap
`ifdef TIMED_COUNTER_BCD_EN
    ,
    output logic [4*DIGITS-1:0]   bcd_data,
    output logic                  bcd_valid
`endif
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);

    localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

    logic [PW-1:0]    pre_reg, pre_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic             tick_reg, tick_next;
    logic             wrap_reg, wrap_next;

    assign count = count_reg;
    assign tick  = tick_reg;
    assign wrap  = wrap_reg;

    // Next-state: clear beats load beats a prescaler step; en only gates steps.
    always_comb begin
        count_next = count_reg;
        pre_next   = pre_reg;
        tick_next  = 1'b0;
        wrap_next  = 1'b0;
        if (clear) begin
            count_next = '0;
            pre_next   = '0;
        end else if (load) begin
            count_next = (load_val > MAX_W) ? MAX_W : load_val;
            pre_next   = '0;
        end else if (en) begin
            if (pre_reg == PRE_LAST) begin
                pre_next  = '0;
                tick_next = 1'b1;
                if (!dir) begin
                    if (count_reg >= MAX_W) begin
                        count_next = '0;
                        wrap_next  = 1'b1;
                    end else begin
                        count_next = count_reg + ONE_W;
                    end
                end else begin
                    if (count_reg == '0) begin
                        count_next = MAX_W;
                        wrap_next  = 1'b1;
                    end else begin
                        count_next = count_reg - ONE_W;
                    end
                end
            end else begin
                pre_next = pre_reg + PRE_ONE;
            end
        end
    end

    // Counter, prescaler and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            pre_reg   <= '0;
            tick_reg  <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            pre_reg   <= pre_next;
            tick_reg  <= tick_next;
            wrap_reg  <= wrap_next;
        end
    end

`ifdef TIMED_COUNTER_BCD_EN
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]    bin_reg;
    logic [4*DIGITS-1:0] acc_reg;
    logic [4*DIGITS-1:0] acc_adj;
    logic [4*DIGITS-1:0] acc_shift;
    logic [CW-1:0]       bit_cnt_reg;
    logic [4*DIGITS-1:0] bcd_data_reg;
    logic                bcd_valid_reg;
    logic                count_change;

    assign bcd_data     = bcd_data_reg;
    assign bcd_valid    = bcd_valid_reg;
    assign count_change = (count_next != count_reg);

    // Add-3 correction on every digit that would overflow past 9 when doubled.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5)
                                      ? (acc_reg[4*gi +: 4] + 4'd3)
                                      : acc_reg[4*gi +: 4];
        end
    endgenerate

    assign acc_shift = {acc_adj[4*DIGITS-2:0], bin_reg[WIDTH-1]};

    // One bit per cycle; any count change restarts from the new value so a
    // stale result can never be published as valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_reg       <= '0;
            acc_reg       <= '0;
            bit_cnt_reg   <= '0;
            bcd_data_reg  <= '0;
            bcd_valid_reg <= 1'b1;
        end else if (count_change) begin
            bin_reg       <= count_next;
            acc_reg       <= '0;
            bit_cnt_reg   <= CW'(WIDTH);
            bcd_valid_reg <= 1'b0;
        end else if (bit_cnt_reg != '0) begin
            bin_reg     <= {bin_reg[WIDTH-2:0], 1'b0};
            acc_reg     <= acc_shift;
            bit_cnt_reg <= bit_cnt_reg - CW'(1);
            if (bit_cnt_reg == CW'(1)) begin
                bcd_data_reg  <= acc_shift;
                bcd_valid_reg <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_timed_counter.sv
// Directed self-checking bench for timed_counter (DIV=10, MAX_VAL=5).
// BCD checks compile only when TIMED_COUNTER_BCD_EN is defined.
module tb_timed_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       dir;
    logic       clear;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tick;
    logic       wrap;
`ifdef TIMED_COUNTER_BCD_EN
    logic [7:0] bcd_data;
    logic       bcd_valid;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    timed_counter #(
        .CLK_HZ (10),
        .TICK_HZ(1),
        .WIDTH  (8),
        .MAX_VAL(5),
        .DIGITS (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .dir     (dir),
        .clear   (clear),
        .load    (load),
        .load_val(load_val),
        .count   (count),
        .tick    (tick),
        .wrap    (wrap)
`ifdef TIMED_COUNTER_BCD_EN
        ,
        .bcd_data (bcd_data),
        .bcd_valid(bcd_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock and land 1ns past the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; dir = 1'b0; clear = 1'b0; load = 1'b0; load_val = 8'd0;
        #12;
        tests_run++;
        if (count !== 8'd0 || tick !== 1'b0 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: count=%0d tick=%b wrap=%b, required 0/0/0", count, tick, wrap);
        end
`ifdef TIMED_COUNTER_BCD_EN
        tests_run++;
        if (bcd_data !== 8'h00 || bcd_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_bcd: bcd_data=%h valid=%b, required 00/1", bcd_data, bcd_valid);
        end
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en    = 1'b1;
    endtask

    task automatic test_up_count();
        logic [7:0] exp_cnt [6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
        logic [7:0] prev = 8'd0;
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < 9; c++) begin
                cyc();
                tests_run++;
                if (tick !== 1'b0 || wrap !== 1'b0 || count !== prev) begin
                    tests_failed++;
                    $display("FAIL up_idle[%0d.%0d]: count=%0d tick=%b wrap=%b, required %0d/0/0", k, c, count, tick, wrap, prev);
                end
            end
            cyc();
            tests_run++;
            if (tick !== 1'b1 || count !== exp_cnt[k] || wrap !== (k == 5)) begin
                tests_failed++;
                $display("FAIL up_step[%0d]: count=%0d tick=%b wrap=%b, required %0d/1/%b", k, count, tick, wrap, exp_cnt[k], (k == 5));
            end
            prev = exp_cnt[k];
        end
    endtask

    task automatic test_down_count();
        logic [7:0] exp_cnt [3] = '{8'd5, 8'd4, 8'd3};
        logic       exp_wrap [3] = '{1'b1, 1'b0, 1'b0};
        dir = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 9; c++) cyc();
            cyc();
            tests_run++;
            if (tick !== 1'b1 || count !== exp_cnt[k] || wrap !== exp_wrap[k]) begin
                tests_failed++;
                $display("FAIL down_step[%0d]: count=%0d tick=%b wrap=%b, required %0d/1/%b", k, count, tick, wrap, exp_cnt[k], exp_wrap[k]);
            end
        end
    endtask

    task automatic test_pause();
        for (int c = 0; c < 4; c++) cyc();
        en = 1'b0;
        for (int c = 0; c < 7; c++) begin
            cyc();
            tests_run++;
            if (tick !== 1'b0 || count !== 8'd3) begin
                tests_failed++;
                $display("FAIL pause_hold[%0d]: count=%0d tick=%b, required 3/0", c, count, tick);
            end
        end
        en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            tests_run++;
            if (tick !== 1'b0) begin
                tests_failed++;
                $display("FAIL pause_resume_early[%0d]: tick=%b, required 0", c, tick);
            end
        end
        cyc();
        tests_run++;
        if (tick !== 1'b1 || count !== 8'd2) begin
            tests_failed++;
            $display("FAIL pause_resume_step: count=%0d tick=%b, required 2/1", count, tick);
        end
    endtask

    task automatic test_load_on_step();
        dir = 1'b0;
        for (int c = 0; c < 9; c++) cyc();
        load = 1'b1; load_val = 8'd200;
        cyc();
        load = 1'b0;
        tests_run++;
        if (count !== 8'd5 || tick !== 1'b0 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_clamp: count=%0d tick=%b wrap=%b, required 5/0/0", count, tick, wrap);
        end
        for (int c = 0; c < 9; c++) begin
            cyc();
            tests_run++;
            if (tick !== 1'b0) begin
                tests_failed++;
                $display("FAIL load_period[%0d]: tick=%b, required 0", c, tick);
            end
        end
        cyc();
        tests_run++;
        if (tick !== 1'b1 || count !== 8'd0 || wrap !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_next_step: count=%0d tick=%b wrap=%b, required 0/1/1", count, tick, wrap);
        end
    endtask

    task automatic test_clear_load();
        load = 1'b1; load_val = 8'd3;
        cyc();
        load = 1'b0;
        tests_run++;
        if (count !== 8'd3) begin
            tests_failed++;
            $display("FAIL load_in_range: count=%0d, required 3", count);
        end
        for (int c = 0; c < 9; c++) cyc();
        clear = 1'b1; load = 1'b1; load_val = 8'd4;
        cyc();
        clear = 1'b0; load = 1'b0;
        tests_run++;
        if (count !== 8'd0 || tick !== 1'b0 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_over_load: count=%0d tick=%b wrap=%b, required 0/0/0", count, tick, wrap);
        end
        for (int c = 0; c < 9; c++) begin
            cyc();
            tests_run++;
            if (tick !== 1'b0) begin
                tests_failed++;
                $display("FAIL clear_period[%0d]: tick=%b, required 0", c, tick);
            end
        end
        cyc();
        tests_run++;
        if (tick !== 1'b1 || count !== 8'd1 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_next_step: count=%0d tick=%b wrap=%b, required 1/1/0", count, tick, wrap);
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 5; c++) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (count !== 8'd0 || tick !== 1'b0 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: count=%0d tick=%b wrap=%b, required 0/0/0", count, tick, wrap);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 9; c++) begin
            cyc();
            tests_run++;
            if (tick !== 1'b0) begin
                tests_failed++;
                $display("FAIL post_reset_period[%0d]: tick=%b, required 0", c, tick);
            end
        end
        cyc();
        tests_run++;
        if (tick !== 1'b1 || count !== 8'd1) begin
            tests_failed++;
            $display("FAIL post_reset_step: count=%0d tick=%b, required 1/1", count, tick);
        end
    endtask

`ifdef TIMED_COUNTER_BCD_EN
    task automatic test_bcd();
        en = 1'b0;
        for (int c = 0; c < 10; c++) cyc();
        tests_run++;
        if (bcd_valid !== 1'b1 || bcd_data !== 8'h01) begin
            tests_failed++;
            $display("FAIL bcd_settled: bcd_data=%h valid=%b, required 01/1", bcd_data, bcd_valid);
        end
        load = 1'b1; load_val = 8'd4;
        cyc();
        load = 1'b0;
        tests_run++;
        if (bcd_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bcd_drop: valid=%b, required 0", bcd_valid);
        end
        cyc();
        cyc();
        load = 1'b1; load_val = 8'd2;
        cyc();
        load = 1'b0;
        for (int c = 0; c < 7; c++) begin
            cyc();
            tests_run++;
            if (bcd_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL bcd_busy[%0d]: valid=%b, required 0", c, bcd_valid);
            end
        end
        cyc();
        tests_run++;
        if (bcd_valid !== 1'b1 || bcd_data !== 8'h02) begin
            tests_failed++;
            $display("FAIL bcd_result: bcd_data=%h valid=%b, required 02/1", bcd_data, bcd_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_up_count();
        test_down_count();
        test_pause();
        test_load_on_step();
        test_clear_load();
        test_async_reset();
`ifdef TIMED_COUNTER_BCD_EN
        test_bcd();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
